// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB strobe sequencer with memory-wait watchdog.
// Optional perf counters (instret/cycles) enabled by defining CPU_SEQ_PERF_COUNTERS_EN.
module cpu_sequencer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        mem_addr_sel,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        halted,
  output logic        illegal_op,
  output logic        bus_error,
  output logic [2:0]  state_out,
  output logic [15:0] instret,
  output logic [15:0] cycles
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LD  = 4'b1000;
  localparam logic [3:0] OP_ST  = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1010;
  localparam logic [3:0] OP_JMP = 4'b1011;
  localparam logic [3:0] OP_HLT = 4'b1110;

  state_t                state, state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_nxt;
  logic                  wait_hit, timeout, illegal_set;
  logic                  ir_c, pci_c, pcl_c, sel_c, rd_c, wr_c, rw_c;

  assign wait_hit = !mem_ready && (wait_cnt == WAIT_CNT_W'(MEM_WAIT_MAX - 1));

  always_comb begin
    state_nxt   = state;
    timeout     = 1'b0;
    illegal_set = 1'b0;
    ir_c  = 1'b0;
    pci_c = 1'b0;
    pcl_c = 1'b0;
    sel_c = 1'b0;
    rd_c  = 1'b0;
    wr_c  = 1'b0;
    rw_c  = 1'b0;
    case (state)
      FETCH: begin
        rd_c = 1'b1;
        if (mem_ready) begin
          ir_c      = 1'b1;
          pci_c     = 1'b1;
          state_nxt = DECODE;
        end else if (wait_hit) begin
          timeout   = 1'b1;
          state_nxt = HALT;
        end
      end
      DECODE: begin
        if (opcode == OP_HLT) begin
          state_nxt = HALT;
        end else if (opcode == 4'b1100 || opcode == 4'b1101 || opcode == 4'b1111) begin
          illegal_set = 1'b1;
          state_nxt   = FETCH;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = FETCH;
        if (opcode == OP_NOP) begin
          state_nxt = FETCH;
        end else if (opcode <= 4'b0111) begin
          state_nxt = WB;
        end else if (opcode == OP_LD || opcode == OP_ST) begin
          state_nxt = MEM;
        end else if (opcode == OP_JMP) begin
          pcl_c = 1'b1;
        end else if (opcode == OP_BEQ) begin
          pcl_c = zero_flag;
        end
      end
      MEM: begin
        sel_c = 1'b1;
        if (opcode == OP_LD) rd_c = 1'b1;
        else                 wr_c = 1'b1;
        if (mem_ready) begin
          state_nxt = (opcode == OP_LD) ? WB : FETCH;
        end else if (wait_hit) begin
          timeout   = 1'b1;
          state_nxt = HALT;
        end
      end
      WB: begin
        rw_c      = 1'b1;
        state_nxt = FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // Strobes are forced low while reset is held, since reset parks the FSM in FETCH.
  always_comb begin
    ir_load      = ir_c  & ~reset;
    pc_inc       = pci_c & ~reset;
    pc_load      = pcl_c & ~reset;
    mem_addr_sel = sel_c & ~reset;
    mem_read     = rd_c  & ~reset;
    mem_write    = wr_c  & ~reset;
    reg_write    = rw_c  & ~reset;
  end

  always_comb begin
    wait_nxt = wait_cnt;
    if (state_nxt != state && (state_nxt == FETCH || state_nxt == MEM))
      wait_nxt = '0;
    else if (mem_ready)
      wait_nxt = '0;
    else if (state == FETCH || state == MEM)
      wait_nxt = wait_cnt + WAIT_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      wait_cnt   <= '0;
      illegal_op <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      illegal_op <= illegal_op | illegal_set;
      bus_error  <= bus_error | timeout;
    end
  end

  assign halted    = (state == HALT);
  assign state_out = state;

`ifdef CPU_SEQ_PERF_COUNTERS_EN
  logic retire;
  assign retire = (state_nxt == FETCH) &&
                  (state == DECODE || state == EXEC || state == MEM || state == WB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
      cycles  <= '0;
    end else begin
      if (state != HALT) cycles  <= cycles + 16'd1;
      if (retire)        instret <= instret + 16'd1;
    end
  end
`else
  assign instret = '0;
  assign cycles  = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: per-cycle expected strobe vectors are queued
// as inputs are driven and popped for comparison at the following falling edge.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  opcode = 4'b0000;
  logic        zero_flag = 1'b0;
  logic        mem_ready = 1'b1;
  logic        ir_load, pc_inc, pc_load, mem_addr_sel, mem_read, mem_write, reg_write;
  logic        halted, illegal_op, bus_error;
  logic [2:0]  state_out;
  logic [15:0] instret, cycles;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  bit          ill_e = 1'b0;
  bit          be_e  = 1'b0;
  logic [12:0] exp_q[$];
  logic [12:0] outs;

  cpu_sequencer #(.MEM_WAIT_MAX(15), .WAIT_CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .mem_addr_sel(mem_addr_sel), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .halted(halted), .illegal_op(illegal_op),
    .bus_error(bus_error), .state_out(state_out), .instret(instret), .cycles(cycles)
  );

  always #5 clk = ~clk;

  assign outs = {ir_load, pc_inc, pc_load, mem_addr_sel, mem_read, mem_write,
                 reg_write, halted, illegal_op, bus_error, state_out};

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {ir,pci,pcl,sel,rd,wr,rw,halted,illegal,bus_err,state}
  function automatic logic [12:0] ev(bit ir, bit pci, bit pcl, bit sel, bit rd,
                                     bit wr, bit rw, bit h, logic [2:0] st);
    return {ir, pci, pcl, sel, rd, wr, rw, h, ill_e, be_e, st};
  endfunction

  function automatic logic [12:0] fe(bit rdy); return ev(rdy, rdy, 0, 0, 1, 0, 0, 0, 3'd0); endfunction
  function automatic logic [12:0] de();        return ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd1);     endfunction
  function automatic logic [12:0] ex(bit pcl); return ev(0, 0, pcl, 0, 0, 0, 0, 0, 3'd2);   endfunction
  function automatic logic [12:0] mm(bit ld);  return ev(0, 0, 0, 1, ld, !ld, 0, 0, 3'd3);  endfunction
  function automatic logic [12:0] wb();        return ev(0, 0, 0, 0, 0, 0, 1, 0, 3'd4);     endfunction
  function automatic logic [12:0] ht();        return ev(0, 0, 0, 0, 0, 0, 0, 1, 3'd5);     endfunction

  // Called just after a rising edge; leaves just after the next rising edge.
  task automatic step(input string tag, input logic [3:0] op, input logic rdy,
                      input logic zf, input logic [12:0] e);
    opcode    = op;
    mem_ready = rdy;
    zero_flag = zf;
    exp_q.push_back(e);
    @(negedge clk);
    check_eq(tag, {3'b000, outs}, {3'b000, exp_q.pop_front()});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ill_e = 1'b0;
    be_e  = 1'b0;
    #1;
    check_eq("rst_async", {3'b000, outs}, 16'h0000);
    @(negedge clk);
    check_eq("rst_held", {3'b000, outs}, 16'h0000);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_alu(input logic [3:0] op);
    step("alu_fetch", op, 1, 0, fe(1));
    step("alu_decode", op, 1, 0, de());
    step("alu_exec", op, 1, 0, ex(0));
    step("alu_wb", op, 1, 0, wb());
  endtask

  initial begin
    #2;
    mem_ready = 1'b1;
    do_reset();

    for (int i = 0; i < 4; i++) run_alu(4'b0001);
    `ifdef CPU_SEQ_PERF_COUNTERS_EN
      check_eq("instret", instret, 16'd4);
      check_eq("cycles", cycles, 16'd16);
    `else
      check_eq("instret_off", instret, 16'd0);
      check_eq("cycles_off", cycles, 16'd0);
    `endif

    // LD with three wait cycles in MEM
    step("ld_fetch", 4'b1000, 1, 0, fe(1));
    step("ld_decode", 4'b1000, 1, 0, de());
    step("ld_exec", 4'b1000, 1, 0, ex(0));
    for (int i = 0; i < 3; i++) step("ld_mem_wait", 4'b1000, 0, 0, mm(1));
    step("ld_mem_done", 4'b1000, 1, 0, mm(1));
    step("ld_wb", 4'b1000, 1, 0, wb());

    // BEQZ taken / not taken, JMP, NOP
    step("beqz1_fetch", 4'b1010, 1, 1, fe(1));
    step("beqz1_decode", 4'b1010, 1, 1, de());
    step("beqz1_exec", 4'b1010, 1, 1, ex(1));
    step("beqz0_fetch", 4'b1010, 1, 0, fe(1));
    step("beqz0_decode", 4'b1010, 1, 0, de());
    step("beqz0_exec", 4'b1010, 1, 0, ex(0));
    step("jmp_fetch", 4'b1011, 1, 0, fe(1));
    step("jmp_decode", 4'b1011, 1, 0, de());
    step("jmp_exec", 4'b1011, 1, 0, ex(1));
    step("nop_fetch", 4'b0000, 1, 0, fe(1));
    step("nop_decode", 4'b0000, 1, 0, de());
    step("nop_exec", 4'b0000, 1, 0, ex(0));

    // ST zero-wait, then fetch stalls
    step("st_fetch", 4'b1001, 1, 0, fe(1));
    step("st_decode", 4'b1001, 1, 0, de());
    step("st_exec", 4'b1001, 1, 0, ex(0));
    step("st_mem", 4'b1001, 1, 0, mm(0));
    step("fetch_wait", 4'b0111, 0, 0, fe(0));
    step("fetch_wait", 4'b0111, 0, 0, fe(0));
    step("mov_fetch", 4'b0111, 1, 0, fe(1));
    step("mov_decode", 4'b0111, 1, 0, de());
    step("mov_exec", 4'b0111, 1, 0, ex(0));
    step("mov_wb", 4'b0111, 1, 0, wb());

    // illegal opcode is sticky, execution continues
    step("ill_fetch", 4'b1101, 1, 0, fe(1));
    step("ill_decode", 4'b1101, 1, 0, de());
    ill_e = 1'b1;
    run_alu(4'b0010);

    // HALT absorbs until reset
    step("hlt_fetch", 4'b1110, 1, 0, fe(1));
    step("hlt_decode", 4'b1110, 1, 0, de());
    for (int i = 0; i < 3; i++) step("halt_hold", 4'b0001, 1, 0, ht());
    do_reset();
    run_alu(4'b0011);

    // ST watchdog: 15 waiting cycles then HALT with bus_error
    step("wd_fetch", 4'b1001, 1, 0, fe(1));
    step("wd_decode", 4'b1001, 1, 0, de());
    step("wd_exec", 4'b1001, 0, 0, ex(0));
    for (int i = 0; i < 15; i++) step("wd_mem_wait", 4'b1001, 0, 0, mm(0));
    be_e = 1'b1;
    step("wd_halt", 4'b1001, 0, 0, ht());
    step("wd_halt_rdy", 4'b1001, 1, 0, ht());
    do_reset();

    // reset in the middle of a memory access
    step("ab_fetch", 4'b1000, 1, 0, fe(1));
    step("ab_decode", 4'b1000, 1, 0, de());
    step("ab_exec", 4'b1000, 1, 0, ex(0));
    step("ab_mem_wait", 4'b1000, 0, 0, mm(1));
    do_reset();
    run_alu(4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
